gcd_engine: RTL and testbench

- Sequential subtract-and-compare GCD engine for two unsigned 16-bit operands.
- Holds the two operand registers and the control FSM that feed the combinational SUB subtractor (out = in1 - in2, 16-bit) directly downstream.
- Each cycle it consumes SUB's difference and writes it back into the larger operand register.
- Start/done handshake toward the system side; reports the result and the subtraction count.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/SUB.sv | 16 +
 rtl/gcd_engine.sv | 126 ++++++++++++
 tb/tb_gcd_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM state type and the fixed
// datapath width of the SUB subtractor.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/SUB.sv
// SUB: 16-bit combinational subtractor used by the GCD datapath.
// Ports:
//   in1 - minuend
//   in2 - subtrahend
//   out - in1 - in2 (modulo 2^16)
module SUB
    import gcd_pkg::*;
(
    input  logic [GCD_WIDTH-1:0] in1,
    input  logic [GCD_WIDTH-1:0] in2,
    output logic [GCD_WIDTH-1:0] out
);

    assign out = in1 - in2;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: sequential subtract-and-compare GCD of two unsigned operands.
// Each RUN cycle the larger operand register is replaced by the difference
// of the two registers until a terminal condition yields the result.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - request, sampled only in IDLE
//   a_in     - operand A, latched on accepted start
//   b_in     - operand B, latched on accepted start
//   busy     - high while computing
//   done     - one-cycle pulse when gcd_out/iter_cnt are valid
//   gcd_out  - result, held until the next accepted start
//   iter_cnt - number of subtractions performed, held with gcd_out
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_cnt
);

    // The subtractor is a fixed 16-bit block; any other width cannot work.
    if (WIDTH != GCD_WIDTH) begin : g_bad_width
        $error("gcd_engine: WIDTH must equal GCD_WIDTH (16)");
    end

    state_t           state;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;

    logic             a_gt_b;
    logic [WIDTH-1:0] sub_in1;
    logic [WIDTH-1:0] sub_in2;
    logic [WIDTH-1:0] diff;
    logic             finish;
    logic [WIDTH-1:0] result;

    // Larger operand always goes to in1, so the difference never wraps.
    always_comb begin
        a_gt_b  = rega > regb;
        sub_in1 = a_gt_b ? rega : regb;
        sub_in2 = a_gt_b ? regb : rega;
    end

    SUB u_sub (
        .in1 (sub_in1),
        .in2 (sub_in2),
        .out (diff)
    );

    // Terminal checks in priority order: B zero, A zero, A equal to B.
    always_comb begin
        finish = 1'b0;
        result = rega;
        if (regb == '0) begin
            finish = 1'b1;
            result = rega;
        end else if (rega == '0) begin
            finish = 1'b1;
            result = regb;
        end else if (rega == regb) begin
            finish = 1'b1;
            result = rega;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rega     <= '0;
            regb     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gcd_out  <= '0;
            iter_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rega     <= a_in;
                        regb     <= b_in;
                        gcd_out  <= '0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (finish) begin
                        gcd_out <= result;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        if (a_gt_b) begin
                            rega <= diff;
                        end else begin
                            regb <= diff;
                        end
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine. Expected results come from a Euclidean
// (division-based) reference model: the subtraction count is the sum of the
// Euclid quotients minus one, since the engine stops when both are equal.
module tb_gcd_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] gcd_out;
    logic [15:0] iter_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    gcd_engine #(
        .WIDTH (16),
        .CNT_W (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .gcd_out  (gcd_out),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned k);
        int unsigned x, y, t;
        k = 0;
        if (a == 0) begin
            g = b;
        end else if (b == 0) begin
            g = a;
        end else begin
            x = a;
            y = b;
            while (y != 0) begin
                k += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = x;
            k -= 1;
        end
    endfunction

    // Called at a negedge while the engine is idle; returns just after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
    endtask

    // Follows a run cycle by cycle; returns at the negedge of the done cycle.
    // inject: pulse a competing start request mid-run, which must be ignored.
    task automatic finish_run(input logic [15:0] a, input logic [15:0] b, input bit inject);
        int unsigned g, k, c;
        bit seen, busy_ok;
        ref_gcd(a, b, g, k);
        c       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && c < k + 10) begin
            @(negedge clk);
            c++;
            if (inject && c == 2) begin
                start = 1'b1;
                a_in  = 16'd9;
                b_in  = 16'd3;
            end else if (inject && c == 3) begin
                start = 1'b0;
            end
            if (c == 1) begin
                check("busy_first", busy, 1);
                check("gcd_cleared", gcd_out, 0);
                check("cnt_cleared", iter_cnt, 0);
            end
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check("done_seen", seen, 1);
        check("latency", c, k + 2);
        check("busy_held", busy_ok, 1);
        check("busy_at_done", busy, 0);
        check("gcd", gcd_out, g);
        check("iter_cnt", iter_cnt, k);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b);
        launch(a, b);
        finish_run(a, b, 1'b0);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gcd", gcd_out, 0);
        check("rst_cnt", iter_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference case with a competing start pulse mid-run.
        launch(16'd48, 16'd18);
        finish_run(16'd48, 16'd18, 1'b1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("hold_gcd", gcd_out, 6);

        run(16'd0, 16'd7);
        run(16'd0, 16'd0);
        run(16'd7, 16'd0);
        run(16'd1234, 16'd1234);
        run(16'd65535, 16'd1);

        // Start held through DONE is taken only in the following IDLE cycle.
        launch(16'd100, 16'd75);
        finish_run(16'd100, 16'd75, 1'b0);
        start = 1'b1;
        a_in  = 16'd35;
        b_in  = 16'd21;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_gcd_hold", gcd_out, 25);
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(16'd35, 16'd21, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        launch(16'd48, 16'd18);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_gcd", gcd_out, 0);
        check("arst_cnt", iter_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", busy, 0);
        run(16'd35, 16'd21);

        // Randomized operands: small values (zeros likely) and wide values.
        for (int i = 0; i < 12; i++) begin
            run(16'($urandom_range(0, 20)), 16'($urandom_range(0, 20)));
        end
        for (int i = 0; i < 20; i++) begin
            run(16'($urandom_range(256, 65535)), 16'($urandom_range(256, 65535)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
